// File: rtl/jtframe_ram16_ctrl_pkg.sv
// Shared types and constants for the jtframe_ram16 CPU-side controller.
package jtframe_ram16_ctrl_pkg;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] DEF_CLR_VAL = 16'h0000;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDQ,
    ST_DONE
  } state_t;

  // Active-low CPU strobes become active-high RAM byte enables.
  function automatic logic [1:0] dsn_to_we(input logic [1:0] dsn);
    return ~dsn;
  endfunction

endpackage

// File: rtl/jtframe_ram16.sv
// 16-bit dual-byte RAM with per-byte write enables and registered read.
module jtframe_ram16 #(
  parameter int unsigned aw = 10
) (
  input  logic          clk,
  input  logic [aw-1:0] addr,
  input  logic [15:0]   data,
  input  logic [1:0]    we,
  output logic [15:0]   q
);

  localparam int unsigned DEPTH = 1 << aw;

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= data[7:0];
    if (we[1]) mem[addr][15:8] <= data[15:8];
    q <= mem[addr];
  end

endmodule

// File: rtl/jtframe_ram16_clr_cnt.sv
// Word-address counter used to sweep the whole RAM during a clear.
module jtframe_ram16_clr_cnt #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          busy,
  output logic [AW-1:0] cnt,
  output logic          last
);

  // Restart wins over counting; the counter wraps to 0 after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + AW'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/jtframe_ram16_ctrl.sv
// CPU-side sequencer for jtframe_ram16: power-up/requested clear, then
// word/byte accesses over a level-sensitive cs/ok handshake.
module jtframe_ram16_ctrl
  import jtframe_ram16_ctrl_pkg::*;
#(
  parameter int unsigned   AW      = 10,
  parameter logic [DW-1:0] CLR_VAL = DEF_CLR_VAL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [1:0]    cpu_dsn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_ok,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic [1:0]    ram_we,
  input  logic [DW-1:0] ram_q
);

  state_t        state;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic [1:0]    lat_dsn;
  logic [AW-1:0] clr_cnt;
  logic          clr_last;

  assign clr_busy = (state == ST_CLR);

  jtframe_ram16_clr_cnt #(.AW(AW)) u_clr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (clr),
    .busy  (clr_busy),
    .cnt   (clr_cnt),
    .last  (clr_last)
  );

  // A clear request overrides everything; a write in WR has already been
  // presented to the RAM this cycle, so it lands before the clear sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLR;
      cpu_din  <= '0;
      cpu_ok   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_dsn  <= '0;
    end else if (clr) begin
      state  <= ST_CLR;
      cpu_ok <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          if (clr_last) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cpu_cs) begin
            lat_addr <= cpu_addr;
            lat_data <= cpu_dout;
            lat_dsn  <= cpu_dsn;
            state    <= cpu_rnw ? ST_RD : ST_WR;
          end
        end
        ST_WR: begin
          state  <= ST_DONE;
          cpu_ok <= 1'b1;
        end
        ST_RD: begin
          state <= ST_RDQ;
        end
        ST_RDQ: begin
          cpu_din <= ram_q;
          state   <= ST_DONE;
          cpu_ok  <= 1'b1;
        end
        ST_DONE: begin
          if (!cpu_cs) begin
            state  <= ST_IDLE;
            cpu_ok <= 1'b0;
          end
        end
        default: begin
          state  <= ST_CLR;
          cpu_ok <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: the clear sweep owns the port while busy.
  always_comb begin
    ram_addr = lat_addr;
    ram_data = lat_data;
    ram_we   = 2'b00;
    case (state)
      ST_CLR: begin
        ram_addr = clr_cnt;
        ram_data = CLR_VAL;
        ram_we   = 2'b11;
      end
      ST_WR: begin
        ram_we = dsn_to_we(lat_dsn);
      end
      default: begin
        ram_we = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_jtframe_ram16_ctrl.sv
// Directed bench for jtframe_ram16_ctrl driving a jtframe_ram16 instance.
module tb_jtframe_ram16_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned NW = 1 << AW;
  localparam logic [15:0] CV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          cpu_cs = 1'b0;
  logic          cpu_rnw = 1'b1;
  logic [1:0]    cpu_dsn = 2'b00;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_dout = '0;
  logic [15:0]   cpu_din;
  logic          cpu_ok;
  logic          clr_busy;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic [1:0]    ram_we;
  logic [15:0]   ram_q;

  int n_cmp = 0;
  int n_err = 0;
  int clr_cycles = 0;
  int wr_cycles = 0;
  logic [NW-1:0] clr_mask = '0;
  logic [15:0] mdl [NW];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  jtframe_ram16_ctrl #(.AW(AW), .CLR_VAL(CV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .cpu_cs   (cpu_cs),
    .cpu_rnw  (cpu_rnw),
    .cpu_dsn  (cpu_dsn),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_ok   (cpu_ok),
    .clr_busy (clr_busy),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  jtframe_ram16 #(.aw(AW)) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .data (ram_data),
    .we   (ram_we),
    .q    (ram_q)
  );

  // RAM port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (clr_busy) begin
        clr_cycles = clr_cycles + 1;
        if (ram_we == 2'b11 && ram_data == CV) clr_mask[ram_addr] = 1'b1;
      end else if (ram_we != 2'b00) begin
        wr_cycles = wr_cycles + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NW); i++) mdl[i] = CV;
  endtask

  // One full handshake; exp_lat counts edges from the sampling edge to cpu_ok.
  task automatic access(input logic rnw, input logic [AW-1:0] a, input logic [1:0] dsn,
                        input logic [15:0] d, input int exp_lat, input int hold,
                        input string tag);
    int lat;
    int wr0;
    logic okbad;
    wr0 = wr_cycles;
    if (rnw) exp_q.push_back(mdl[a]);
    cpu_rnw = rnw; cpu_addr = a; cpu_dsn = dsn; cpu_dout = d; cpu_cs = 1'b1;
    lat = 0;
    tick(); lat++;
    if (exp_lat <= 3) begin
      cpu_addr = ~a; cpu_dout = ~d; cpu_dsn = ~dsn; cpu_rnw = ~rnw;
    end
    while (!cpu_ok && lat < 60) begin
      tick(); lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    okbad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (cpu_ok !== 1'b1) okbad = 1'b1;
    end
    if (hold > 0) check({tag, "_okhold"}, 32'(okbad), 32'd0);
    cpu_cs = 1'b0;
    tick();
    check({tag, "_okfall"}, 32'(cpu_ok), 32'd0);
    check({tag, "_wecnt"}, 32'(wr_cycles - wr0), (!rnw && dsn != 2'b11) ? 32'd1 : 32'd0);
    if (rnw) begin
      check({tag, "_sbq"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) check({tag, "_din"}, 32'(cpu_din), 32'(exp_q.pop_front()));
    end else begin
      if (!dsn[1]) mdl[a][15:8] = d[15:8];
      if (!dsn[0]) mdl[a][7:0]  = d[7:0];
    end
  endtask

  initial begin
    int lat;
    logic bad;

    // Reset state
    #12;
    check("rst_busy", 32'(clr_busy), 32'd1);
    check("rst_ok", 32'(cpu_ok), 32'd0);
    check("rst_din", 32'(cpu_din), 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    while (clr_busy && lat < 100) begin
      tick(); lat++;
    end
    check("pwr_clr_len", 32'(lat), 32'd16);
    check("pwr_clr_cyc", 32'(clr_cycles), 32'd16);
    check("pwr_clr_mask", 32'(clr_mask), 32'hFFFF);

    // Post-clear content and basic read/write
    tick();
    access(1'b1, 4'd0,  2'b00, 16'h0000, 3, 0, "rd0");
    access(1'b1, 4'd15, 2'b00, 16'h0000, 3, 0, "rd15");
    access(1'b0, 4'd3,  2'b00, 16'h1234, 2, 0, "wr3");
    access(1'b1, 4'd3,  2'b00, 16'h0000, 3, 0, "rd3");
    access(1'b0, 4'd3,  2'b10, 16'hFFEE, 2, 0, "wrlo");
    access(1'b1, 4'd3,  2'b00, 16'h0000, 3, 0, "rdlo");
    access(1'b0, 4'd3,  2'b11, 16'h0000, 2, 0, "wrnone");
    access(1'b1, 4'd3,  2'b00, 16'h0000, 3, 0, "rdnone");
    access(1'b0, 4'd9,  2'b01, 16'hBEEF, 2, 0, "wrhi");
    access(1'b1, 4'd9,  2'b10, 16'h0000, 3, 0, "rdhi");

    // cs held high in DONE for 10 cycles
    access(1'b0, 4'd7,  2'b00, 16'hC0DE, 2, 10, "wrhold");
    access(1'b1, 4'd7,  2'b00, 16'h0000, 3, 10, "rdhold");
    access(1'b1, 4'd3,  2'b00, 16'h0000, 3, 0, "rdprep");

    // clr pulse while a read sits in RD
    cpu_rnw = 1'b1; cpu_addr = 4'd5; cpu_dsn = 2'b00; cpu_cs = 1'b1;
    tick();
    clr = 1'b1; clr_cycles = 0; clr_mask = '0;
    tick();
    clr = 1'b0;
    model_clear();
    bad = 1'b0;
    lat = 0;
    while (!cpu_ok && lat < 60) begin
      if (clr_busy && (cpu_ok !== 1'b0 || cpu_din !== 16'h12EE)) bad = 1'b1;
      tick(); lat++;
    end
    check("abort_hold", 32'(bad), 32'd0);
    check("abort_lat", 32'(lat), 32'd19);
    check("abort_clr_cyc", 32'(clr_cycles), 32'd16);
    check("abort_clr_mask", 32'(clr_mask), 32'hFFFF);
    check("abort_din", 32'(cpu_din), 32'(CV));
    cpu_cs = 1'b0;
    tick();
    check("abort_okfall", 32'(cpu_ok), 32'd0);

    // cs asserted during a requested clear
    clr = 1'b1; clr_cycles = 0; clr_mask = '0;
    tick();
    clr = 1'b0;
    model_clear();
    access(1'b0, 4'd2, 2'b00, 16'h5555, 18, 0, "wrclr");
    check("req_clr_cyc", 32'(clr_cycles), 32'd16);
    check("req_clr_mask", 32'(clr_mask), 32'hFFFF);
    access(1'b1, 4'd2, 2'b00, 16'h0000, 3, 0, "rd2");
    access(1'b1, 4'd3, 2'b00, 16'h0000, 3, 0, "rd3clr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
